// File: rtl/req_arb_pkg.sv
// rtl/req_arb_pkg.sv - shared types, sizes and reset constants for req_arbiter8
package req_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam arb_state_e        RST_STATE = IDLE;
  localparam logic [N_REQ-1:0]  RST_GNT   = '0;
  localparam logic [ID_W-1:0]   RST_ID    = '0;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Bit k of the result is v[(k + amt) mod N_REQ].
  function automatic logic [N_REQ-1:0] rotate_down(input logic [N_REQ-1:0] v,
                                                   input logic [ID_W-1:0]  amt);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> amt;
    return dbl[N_REQ-1:0];
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// rtl/pri_enc8.sv - 8:3 highest-bit-wins priority encoder with enable
module pri_enc8
  import req_arb_pkg::*;
(
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = en && (|req);
    if (en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - 8-requester fixed/round-robin arbiter with hold limit
module req_arbiter8
  import req_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HCW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rr_mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state;
  logic [HCW-1:0]   hold_cnt;
  logic [ID_W-1:0]  last_id;

  logic [ID_W-1:0]  fx_id;
  logic             fx_valid;
  logic [N_REQ-1:0] rr_req;
  logic [ID_W-1:0]  rr_id_rot;
  logic             rr_valid;
  logic [ID_W-1:0]  rr_id;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             hold_last;
  logic             release_req;

  pri_enc8 u_enc_fixed (
    .en    (en),
    .req   (req),
    .id    (fx_id),
    .valid (fx_valid)
  );

  // Rotating by last_id puts requester last_id-1 on the top bit, so the
  // downward search begins just below the previous owner.
  assign rr_req = rotate_down(req, last_id);

  pri_enc8 u_enc_rr (
    .en    (en),
    .req   (rr_req),
    .id    (rr_id_rot),
    .valid (rr_valid)
  );

  assign rr_id       = rr_id_rot + last_id;
  assign win_id      = rr_mode ? rr_id    : fx_id;
  assign win_valid   = rr_mode ? rr_valid : fx_valid;
  assign hold_last   = (hold_cnt == HCW'(MAX_HOLD - 1));
  assign release_req = !req[gnt_id] || !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      gnt       <= RST_GNT;
      gnt_id    <= RST_ID;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= RST_ID;
    end else begin
      case (state)
        GRANT: begin
          if (hold_last) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
          end else if (release_req) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
        default: begin
          timeout <= 1'b0;
          if (win_valid) begin
            state     <= GRANT;
            gnt       <= id_to_onehot(win_id);
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            last_id   <= win_id;
            hold_cnt  <= '0;
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// tb/tb_req_arbiter8.sv - directed and randomized checks for req_arbiter8
module tb_req_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rr_mode;
  logic [7:0] req;

  logic [7:0] g16, g4;
  logic [2:0] id16, id4;
  logic       v16, v4;
  logic       to16, to4;

  int total = 0;
  int bad   = 0;

  req_arbiter8 #(.MAX_HOLD(16), .HCW(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .req(req),
    .gnt(g16), .gnt_id(id16), .gnt_valid(v16), .timeout(to16)
  );

  req_arbiter8 #(.MAX_HOLD(4), .HCW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .req(req),
    .gnt(g4), .gnt_id(id4), .gnt_valid(v4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic chk4_grant(input string tag, input logic [2:0] id);
    logic [7:0] oh;
    oh = 8'h01 << id;
    chk({tag, "_gnt"}, g4, oh);
    chk({tag, "_id"}, id4, id);
    chk({tag, "_valid"}, v4, 1);
    chk({tag, "_to"}, to4, 0);
  endtask

  task automatic chk4_gap(input string tag, input logic to_exp);
    chk({tag, "_gnt"}, g4, 0);
    chk({tag, "_valid"}, v4, 0);
    chk({tag, "_to"}, to4, to_exp);
  endtask

  task automatic inv(input string tag, input logic [7:0] g, input logic [2:0] id,
                     input logic v, input logic pv, input logic [7:0] preq,
                     input int run, input int maxh);
    logic [7:0] oh;
    oh = 8'h01 << id;
    chk({tag, "_onehot"}, $onehot0(g), 1);
    chk({tag, "_valid_or"}, v, |g);
    if (v) chk({tag, "_gnt_id"}, g, oh);
    if (v && !pv) chk({tag, "_req_at_arb"}, preq[id], 1);
    chk({tag, "_hold"}, (run <= maxh), 1);
  endtask

  initial begin
    logic [7:0] preq;
    logic       pv16, pv4;
    int         run16, run4;

    rst_n = 1'b0; en = 1'b0; rr_mode = 1'b0; req = 8'h00;
    repeat (2) step();
    chk("rst_gnt16", g16, 0);
    chk("rst_id16", id16, 0);
    chk("rst_valid16", v16, 0);
    chk("rst_to16", to16, 0);
    chk("rst_gnt4", g4, 0);
    rst_n = 1'b1;

    // Fixed mode, release then next requester
    en = 1'b1; req = 8'b0010_0101;
    step();
    chk("fx_gnt", g16, 8'h20);
    chk("fx_id", id16, 5);
    chk("fx_valid", v16, 1);
    step(); step();
    chk("fx_hold_id", id16, 5);
    req = 8'b0000_0101;
    step();
    chk("fx_gap_valid", v16, 0);
    chk("fx_gap_gnt", g16, 0);
    chk("fx_gap_id", id16, 5);
    chk("fx_gap_to", to16, 0);
    step();
    chk("fx_next_gnt", g16, 8'h04);
    chk("fx_next_id", id16, 2);
    req = 8'h00;
    step(); step();
    chk("fx_idle_valid", v16, 0);

    // Round-robin with all requesting, hold limit 4
    pulse_reset();
    rr_mode = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk4_grant($sformatf("rr_k%0d_c%0d", k, c), 3'(7 - k));
      end
      step();
      chk4_gap($sformatf("rr_gap%0d", k), 1'b1);
    end

    // Fixed mode, single requester times out and is re-granted
    pulse_reset();
    rr_mode = 1'b0; req = 8'h80;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk4_grant($sformatf("to_r%0d_c%0d", r, c), 3'd7);
      end
      step();
      chk4_gap($sformatf("to_gap%0d", r), 1'b1);
    end

    // Disabled arbiter grants nothing
    en = 1'b0; req = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      step();
      chk4_gap($sformatf("dis_%0d", c), 1'b0);
    end

    // Enable dropped mid-grant
    en = 1'b1;
    step();
    chk4_grant("en_g0", 3'd3);
    step();
    chk4_grant("en_g1", 3'd3);
    en = 1'b0;
    step();
    chk4_gap("en_gap", 1'b0);
    chk("en_gap_id", id4, 3);
    step();
    chk4_gap("en_idle", 1'b0);

    // Round-robin continues after last owner 3, then async reset mid-grant
    en = 1'b1; rr_mode = 1'b1; req = 8'hFF;
    step();
    chk4_grant("rr_after3", 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt4", g4, 0);
    chk("arst_valid4", v4, 0);
    chk("arst_id4", id4, 0);
    chk("arst_gnt16", g16, 0);
    #1 rst_n = 1'b1;
    step();
    chk4_grant("arst_regrant", 3'd7);
    chk("arst_regrant16", id16, 7);

    // Random traffic invariants on both instances
    pulse_reset();
    pv16 = 1'b0; pv4 = 1'b0; run16 = 0; run4 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      if ($urandom_range(0, 31) == 0) req = 8'h00;
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) rr_mode = ~rr_mode;
      preq = req;
      step();
      run16 = v16 ? run16 + 1 : 0;
      run4  = v4  ? run4  + 1 : 0;
      inv("rnd16", g16, id16, v16, pv16, preq, run16, 16);
      inv("rnd4",  g4,  id4,  v4,  pv4,  preq, run4,  4);
      pv16 = v16;
      pv4  = v4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
